// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared encodings and entry layout for the trace capture path
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_READ = 2'd3
  } state_t;

  localparam int TRIG_BIT  = 48;
  localparam int STAMP_LSB = 32;
  localparam int STAMP_W   = 16;
  localparam int ENTRY_W   = 49;

endpackage

// File: rtl/trace_if.sv
// rtl/trace_if.sv - drain port carrying captured entries to the debug host
interface trace_if;

  logic                          rd_valid;
  logic                          rd_ready;
  logic [trace_pkg::ENTRY_W-1:0] rd_data;
  logic                          rd_last;

  modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
  modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);

endinterface

// File: rtl/trace_buf.sv
// rtl/trace_buf.sv - circular entry RAM with wrapping write pointer and oldest-first read pointer
module trace_buf
  import trace_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               wrEn,
  input  logic [ENTRY_W-1:0] wrData,
  input  logic               rdLoad,
  input  logic [AW-1:0]      rdCount,
  input  logic               rdAdv,
  output logic [ENTRY_W-1:0] rdData
);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wrPtr;
  logic [AW-1:0]      rdPtr;
  logic [AW-1:0]      wrPtrNext;

  assign wrPtrNext = wrEn ? wrPtr + AW'(1) : wrPtr;
  assign rdData    = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr] <= wrData;
  end

  // A full buffer gives rdCount==0, which correctly lands on the slot about to be overwritten.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      wrPtr <= wrPtrNext;
      if (rdLoad)     rdPtr <= wrPtrNext - rdCount;
      else if (rdAdv) rdPtr <= rdPtr + AW'(1);
    end
  end

endmodule

// File: rtl/trace_ctrl.sv
// rtl/trace_ctrl.sv - triggered writeback trace capture with pre-trigger history and drain port
module trace_ctrl
  import trace_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          arm,
  input  logic [31:0]   trig_mask,
  input  logic [31:0]   trig_value,
  input  logic [AW-1:0] post_count,
  input  logic [31:0]   instrW,
  input  logic          validW,
  output logic [1:0]    state,
  output logic          triggered,
  output logic [AW:0]   fill,
  trace_if.master       rd
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t             st;
  logic [STAMP_W-1:0] stamp;
  logic [AW-1:0]      postLatched;
  logic [AW-1:0]      remaining;
  logic [AW:0]        rdLeft;
  logic [AW:0]        fillNext;
  logic               rdValid;
  logic               rdLast;
  logic               armOk;
  logic               capture;
  logic               hit;
  logic               accept;
  logic               toRead;
  logic [ENTRY_W-1:0] entry;
  logic [ENTRY_W-1:0] bufData;

  always_comb begin
    armOk    = arm && (st == ST_IDLE || st == ST_READ);
    capture  = (st == ST_PRE || st == ST_POST) && validW;
    hit      = (st == ST_PRE) && validW && ((instrW & trig_mask) == (trig_value & trig_mask));
    fillNext = (capture && fill != FULL) ? fill + (AW+1)'(1) : fill;
    accept   = rdValid && rd.rd_ready;
    toRead   = (hit && postLatched == '0) || (st == ST_POST && capture && remaining == AW'(1));
    entry                           = '0;
    entry[TRIG_BIT]                 = hit;
    entry[STAMP_LSB +: STAMP_W]     = stamp;
    entry[STAMP_LSB-1:0]            = instrW;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st          <= ST_IDLE;
      stamp       <= '0;
      triggered   <= 1'b0;
      fill        <= '0;
      postLatched <= '0;
      remaining   <= '0;
      rdLeft      <= '0;
      rdValid     <= 1'b0;
      rdLast      <= 1'b0;
    end else if (armOk) begin
      st          <= ST_PRE;
      stamp       <= '0;
      triggered   <= 1'b0;
      fill        <= '0;
      postLatched <= post_count;
      rdLeft      <= '0;
      rdValid     <= 1'b0;
      rdLast      <= 1'b0;
    end else begin
      stamp <= stamp + STAMP_W'(1);
      if (capture) fill <= fillNext;
      if (hit) triggered <= 1'b1;
      if (toRead) begin
        st      <= ST_READ;
        rdLeft  <= fillNext;
        rdValid <= 1'b1;
        rdLast  <= (fillNext == (AW+1)'(1));
      end else begin
        case (st)
          ST_PRE: if (hit) begin
            st        <= ST_POST;
            remaining <= postLatched;
          end
          ST_POST: if (capture) remaining <= remaining - AW'(1);
          ST_READ: if (accept) begin
            rdLeft <= rdLeft - (AW+1)'(1);
            rdLast <= (rdLeft == (AW+1)'(2));
            if (rdLeft == (AW+1)'(1)) begin
              st      <= ST_IDLE;
              rdValid <= 1'b0;
              rdLast  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  trace_buf #(.DEPTH(DEPTH)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (armOk),
    .wrEn    (capture),
    .wrData  (entry),
    .rdLoad  (toRead),
    .rdCount (fillNext[AW-1:0]),
    .rdAdv   (accept),
    .rdData  (bufData)
  );

  assign state       = st;
  assign rd.rd_valid = rdValid;
  assign rd.rd_last  = rdLast;
  assign rd.rd_data  = bufData;

endmodule

// File: tb/tb_trace_ctrl.sv
// tb/tb_trace_ctrl.sv - directed bench for trace_ctrl capture, trigger and drain
module tb_trace_ctrl;
  import trace_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam logic [31:0] ADDI = 32'h20010001;
  localparam logic [31:0] LW   = 32'h8C220000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          arm;
  logic [31:0]   trig_mask;
  logic [31:0]   trig_value;
  logic [AW-1:0] post_count;
  logic [31:0]   instrW;
  logic          validW;
  logic [1:0]    state;
  logic          triggered;
  logic [AW:0]   fill;

  int checks = 0;
  int errors = 0;

  trace_if rdIf();

  trace_ctrl #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm        (arm),
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
    .post_count (post_count),
    .instrW     (instrW),
    .validW     (validW),
    .state      (state),
    .triggered  (triggered),
    .fill       (fill),
    .rd         (rdIf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ENTRY_W-1:0] mkEntry(input logic flag, input logic [15:0] stp, input logic [31:0] ins);
    return {flag, stp, ins};
  endfunction

  task automatic feed(input logic [31:0] ins, input logic v);
    instrW = ins;
    validW = v;
    tick();
    validW = 1'b0;
  endtask

  task automatic doArm(input logic [AW-1:0] pc, input logic [31:0] m, input logic [31:0] val);
    post_count = pc;
    trig_mask  = m;
    trig_value = val;
    arm        = 1'b1;
    tick();
    arm        = 1'b0;
  endtask

  task automatic drain(input string tag, input logic [ENTRY_W-1:0] exp, input logic lastExp);
    rdIf.rd_ready = 1'b1;
    check({tag, "_valid"}, 64'(rdIf.rd_valid), 64'd1);
    check({tag, "_data"},  64'(rdIf.rd_data),  64'(exp));
    check({tag, "_last"},  64'(rdIf.rd_last),  64'(lastExp));
    tick();
    rdIf.rd_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; arm = 1'b0; validW = 1'b0; instrW = '0;
    trig_mask = '0; trig_value = '0; post_count = '0; rdIf.rd_ready = 1'b0;

    // reset holds everything idle whatever the inputs do
    for (int i = 0; i < 8; i++) begin
      arm = 1'($urandom); validW = 1'($urandom); instrW = $urandom;
      rdIf.rd_ready = 1'($urandom);
      tick();
      check("rst_state", 64'(state), 64'd0);
      check("rst_fill", 64'(fill), 64'd0);
      check("rst_rdvalid", 64'(rdIf.rd_valid), 64'd0);
    end
    arm = 1'b0; validW = 1'b0; rdIf.rd_ready = 1'b0; rst_n = 1'b1;
    tick();
    check("rel_state", 64'(state), 64'd0);
    check("rel_trig", 64'(triggered), 64'd0);
    check("rel_last", 64'(rdIf.rd_last), 64'd0);

    // wrapped capture: 20 addi, lw trigger, 3 post entries
    doArm(4'd3, 32'hFC000000, 32'h8C000000);
    check("w_state_pre", 64'(state), 64'd1);
    check("w_fill0", 64'(fill), 64'd0);
    for (int i = 0; i < 20; i++) feed(ADDI, 1'b1);
    check("w_pre_hold", 64'(state), 64'd1);
    check("w_pre_trig", 64'(triggered), 64'd0);
    check("w_fill_sat", 64'(fill), 64'd16);
    feed(LW, 1'b1);
    check("w_post", 64'(state), 64'd2);
    check("w_trig", 64'(triggered), 64'd1);
    for (int i = 0; i < 3; i++) feed(ADDI, 1'b1);
    check("w_read", 64'(state), 64'd3);
    check("w_fill16", 64'(fill), 64'd16);
    for (int i = 1; i <= 16; i++)
      drain($sformatf("w_rd%0d", i), mkEntry(i == 13, 16'(i + 7), (i == 13) ? LW : ADDI), i == 16);
    check("w_idle", 64'(state), 64'd0);
    check("w_done_valid", 64'(rdIf.rd_valid), 64'd0);
    check("w_fill_kept", 64'(fill), 64'd16);

    // post_count=0, trigger on second instruction
    doArm(4'd0, 32'hFFFFFFFF, LW);
    feed(ADDI, 1'b1);
    check("p0_pre", 64'(state), 64'd1);
    feed(LW, 1'b1);
    check("p0_read", 64'(state), 64'd3);
    check("p0_fill", 64'(fill), 64'd2);
    drain("p0_rd1", mkEntry(1'b0, 16'd0, ADDI), 1'b0);
    drain("p0_rd2", mkEntry(1'b1, 16'd1, LW), 1'b1);
    check("p0_idle", 64'(state), 64'd0);

    // bubbles are skipped (even a matching one) and backpressure holds data
    doArm(4'd0, 32'hFFFFFFFF, LW);
    feed(ADDI, 1'b1);
    feed(LW, 1'b0);
    feed(ADDI, 1'b1);
    feed(LW, 1'b0);
    check("b_fill2", 64'(fill), 64'd2);
    check("b_pre", 64'(state), 64'd1);
    feed(LW, 1'b1);
    check("b_read", 64'(state), 64'd3);
    check("b_fill3", 64'(fill), 64'd3);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 64'(rdIf.rd_valid), 64'd1);
      check("bp_data", 64'(rdIf.rd_data), 64'(mkEntry(1'b0, 16'd0, ADDI)));
      check("bp_last", 64'(rdIf.rd_last), 64'd0);
    end
    drain("b_rd1", mkEntry(1'b0, 16'd0, ADDI), 1'b0);
    drain("b_rd2", mkEntry(1'b0, 16'd2, ADDI), 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("bp_lastdata", 64'(rdIf.rd_data), 64'(mkEntry(1'b1, 16'd4, LW)));
      check("bp_lasthold", 64'(rdIf.rd_last), 64'd1);
    end
    drain("b_rd3", mkEntry(1'b1, 16'd4, LW), 1'b1);
    check("b_idle", 64'(state), 64'd0);

    // arm ignored in POST, honoured in READ
    doArm(4'd3, 32'hFFFFFFFF, LW);
    feed(LW, 1'b1);
    check("a_post", 64'(state), 64'd2);
    arm = 1'b1; post_count = 4'd0; instrW = ADDI; validW = 1'b1;
    tick();
    arm = 1'b0; validW = 1'b0;
    check("a_ign_state", 64'(state), 64'd2);
    check("a_ign_trig", 64'(triggered), 64'd1);
    check("a_ign_fill", 64'(fill), 64'd2);
    feed(ADDI, 1'b1);
    check("a_still_post", 64'(state), 64'd2);
    feed(ADDI, 1'b1);
    check("a_read", 64'(state), 64'd3);
    check("a_fill4", 64'(fill), 64'd4);
    drain("a_rd1", mkEntry(1'b1, 16'd0, LW), 1'b0);
    drain("a_rd2", mkEntry(1'b0, 16'd1, ADDI), 1'b0);
    drain("a_rd3", mkEntry(1'b0, 16'd2, ADDI), 1'b0);
    doArm(4'd0, 32'hFFFFFFFF, LW);
    check("ab_state", 64'(state), 64'd1);
    check("ab_fill", 64'(fill), 64'd0);
    check("ab_trig", 64'(triggered), 64'd0);
    check("ab_valid", 64'(rdIf.rd_valid), 64'd0);
    feed(LW, 1'b1);
    check("ab_read", 64'(state), 64'd3);
    drain("ab_rd1", mkEntry(1'b1, 16'd0, LW), 1'b1);
    check("ab_idle", 64'(state), 64'd0);

    // reset mid-POST
    doArm(4'd5, 32'hFFFFFFFF, LW);
    feed(LW, 1'b1);
    feed(ADDI, 1'b1);
    check("r_post", 64'(state), 64'd2);
    rst_n = 1'b0;
    tick();
    check("r_state", 64'(state), 64'd0);
    check("r_trig", 64'(triggered), 64'd0);
    check("r_fill", 64'(fill), 64'd0);
    check("r_valid", 64'(rdIf.rd_valid), 64'd0);
    check("r_last", 64'(rdIf.rd_last), 64'd0);
    rst_n = 1'b1;
    tick();
    check("r_after", 64'(state), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
